// File: rtl/inst_id_ctrl_pkg.sv
// Shared decode definitions for the instruction identifiers, plus the identifier
// class table used by the dispatch. Both the macros and the package constants are visible to users.
`ifndef INST_ID_DEFS
`define INST_ID_DEFS
`define INST_ID_LEN   6
`define FUNCT3_WIDTH  3
`define FUNCT7_WIDTH  7
`define OPC_LUI       7'b0110111
`define OPC_AUIPC     7'b0010111
`define OPC_JAL       7'b1101111
`define OPC_JALR      7'b1100111
`define OPC_BRANCH    7'b1100011
`define OPC_LOAD      7'b0000011
`define OPC_STORE     7'b0100011
`define OPC_OP_IMM    7'b0010011
`define OPC_OP        7'b0110011
`define F7_BASE       7'b0000000
`define F7_ALT        7'b0100000
`define NONE_ID   6'd0
`define LUI_ID    6'd1
`define AUIPC_ID  6'd2
`define JAL_ID    6'd3
`define JALR_ID   6'd4
`define BEQ_ID    6'd5
`define BNE_ID    6'd6
`define BLT_ID    6'd7
`define BGE_ID    6'd8
`define BLTU_ID   6'd9
`define BGEU_ID   6'd10
`define LB_ID     6'd11
`define LH_ID     6'd12
`define LW_ID     6'd13
`define LBU_ID    6'd14
`define LHU_ID    6'd15
`define SB_ID     6'd16
`define SH_ID     6'd17
`define SW_ID     6'd18
`define ADDI_ID   6'd19
`define SLTI_ID   6'd20
`define SLTIU_ID  6'd21
`define XORI_ID   6'd22
`define ORI_ID    6'd23
`define ANDI_ID   6'd24
`define SLLI_ID   6'd25
`define SRLI_ID   6'd26
`define SRAI_ID   6'd27
`define ADD_ID    6'd28
`define SUB_ID    6'd29
`define SLL_ID    6'd30
`define SLT_ID    6'd31
`define SLTU_ID   6'd32
`define XOR_ID    6'd33
`define SRL_ID    6'd34
`define SRA_ID    6'd35
`define OR_ID     6'd36
`define AND_ID    6'd37
`endif

package inst_id_ctrl_pkg;
   localparam int INST_ID_LEN = `INST_ID_LEN;
   localparam int F3_W        = `FUNCT3_WIDTH;
   localparam int F7_W        = `FUNCT7_WIDTH;
   localparam logic [INST_ID_LEN-1:0] NONE_ID = `NONE_ID;

   typedef enum logic {RUN, HALT} ctrl_state_e;

   typedef enum int {
      CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH,
      CLS_LOAD, CLS_STORE, CLS_OP_IMM, CLS_OP
   } idfr_cls_e;
   localparam int NUM_IDFR = 9;

   function automatic logic [6:0] idfr_opc(input int cls);
      logic [6:0] opc;
      case (cls)
         CLS_LUI:    opc = `OPC_LUI;
         CLS_AUIPC:  opc = `OPC_AUIPC;
         CLS_JAL:    opc = `OPC_JAL;
         CLS_JALR:   opc = `OPC_JALR;
         CLS_BRANCH: opc = `OPC_BRANCH;
         CLS_LOAD:   opc = `OPC_LOAD;
         CLS_STORE:  opc = `OPC_STORE;
         CLS_OP_IMM: opc = `OPC_OP_IMM;
         default:    opc = `OPC_OP;
      endcase
      return opc;
   endfunction

   // Reserved funct encodings inside a known opcode also resolve to NONE_ID.
   function automatic logic [INST_ID_LEN-1:0] idfr_decode(input int cls,
         input logic [F3_W-1:0] f3, input logic [F7_W-1:0] f7);
      logic [INST_ID_LEN-1:0] id;
      id = NONE_ID;
      case (cls)
         CLS_LUI:   id = `LUI_ID;
         CLS_AUIPC: id = `AUIPC_ID;
         CLS_JAL:   id = `JAL_ID;
         CLS_JALR:  id = (f3 == 3'd0) ? `JALR_ID : NONE_ID;
         CLS_BRANCH:
            case (f3)
               3'd0: id = `BEQ_ID;  3'd1: id = `BNE_ID;
               3'd4: id = `BLT_ID;  3'd5: id = `BGE_ID;
               3'd6: id = `BLTU_ID; 3'd7: id = `BGEU_ID;
               default: id = NONE_ID;
            endcase
         CLS_LOAD:
            case (f3)
               3'd0: id = `LB_ID;  3'd1: id = `LH_ID; 3'd2: id = `LW_ID;
               3'd4: id = `LBU_ID; 3'd5: id = `LHU_ID;
               default: id = NONE_ID;
            endcase
         CLS_STORE:
            case (f3)
               3'd0: id = `SB_ID; 3'd1: id = `SH_ID; 3'd2: id = `SW_ID;
               default: id = NONE_ID;
            endcase
         CLS_OP_IMM:
            case (f3)
               3'd0: id = `ADDI_ID;  3'd2: id = `SLTI_ID;
               3'd3: id = `SLTIU_ID; 3'd4: id = `XORI_ID;
               3'd6: id = `ORI_ID;   3'd7: id = `ANDI_ID;
               3'd1: id = (f7 == `F7_BASE) ? `SLLI_ID : NONE_ID;
               default: id = (f7 == `F7_BASE) ? `SRLI_ID :
                             (f7 == `F7_ALT)  ? `SRAI_ID : NONE_ID;
            endcase
         default:
            if (f7 == `F7_BASE)
               case (f3)
                  3'd0: id = `ADD_ID; 3'd1: id = `SLL_ID;
                  3'd2: id = `SLT_ID; 3'd3: id = `SLTU_ID;
                  3'd4: id = `XOR_ID; 3'd5: id = `SRL_ID;
                  3'd6: id = `OR_ID;  default: id = `AND_ID;
               endcase
            else if (f7 == `F7_ALT)
               id = (f3 == 3'd0) ? `SUB_ID : (f3 == 3'd5) ? `SRA_ID : NONE_ID;
      endcase
      return id;
   endfunction
endpackage

// File: rtl/inst_id_ctrl_idfr.sv
// Per-opcode identifiers and the combinational dispatch that enables exactly one of
// them from the opcode and ORs their ids (disabled identifiers drive NONE_ID = 0).
module inst_idfr_unit
   import inst_id_ctrl_pkg::*;
#(
   parameter int CLS = 0
) (
   input  logic                   ce,
   input  logic [F3_W-1:0]        funct3,
   input  logic [F7_W-1:0]        funct7,
   output logic [INST_ID_LEN-1:0] instr_id
);
   assign instr_id = ce ? idfr_decode(CLS, funct3, funct7) : NONE_ID;
endmodule

module inst_idfr_dispatch
   import inst_id_ctrl_pkg::*;
(
   input  logic [6:0]             opcode,
   input  logic [F3_W-1:0]        funct3,
   input  logic [F7_W-1:0]        funct7,
   output logic [NUM_IDFR-1:0]    ce,
   output logic [INST_ID_LEN-1:0] instr_id
);
   logic [NUM_IDFR-1:0][INST_ID_LEN-1:0] ids;

   for (genvar g = 0; g < NUM_IDFR; g++) begin : g_idfr
      assign ce[g] = (opcode == idfr_opc(g));
      inst_idfr_unit #(.CLS(g)) u_idfr (
         .ce       (ce[g]),
         .funct3   (funct3),
         .funct7   (funct7),
         .instr_id (ids[g])
      );
   end

   always_comb begin
      instr_id = NONE_ID;
      for (int i = 0; i < NUM_IDFR; i++) instr_id |= ids[i];
   end
endmodule

// File: rtl/inst_id_ctrl.sv
// Decode-stage controller: identifies fetched instructions, buffers them in a
// head + skid elastic pair, and halts on an unidentified instruction until flush.
module inst_id_ctrl
   import inst_id_ctrl_pkg::*;
#(
   parameter int INST_W = 32,
   parameter int PC_W   = 32,
   parameter int CNT_W  = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INST_W-1:0]      in_inst,
   input  logic [PC_W-1:0]        in_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INST_ID_LEN-1:0] out_instr_id,
   output logic [INST_W-1:0]      out_inst,
   output logic [PC_W-1:0]        out_pc,
   output logic                   out_illegal,
   output logic                   halted,
   output logic [CNT_W-1:0]       dec_cnt
);
   typedef struct packed {
      logic [INST_ID_LEN-1:0] id;
      logic [INST_W-1:0]      inst;
      logic [PC_W-1:0]        pc;
   } entry_t;

   ctrl_state_e                state;
   entry_t                     head, skid, new_e;
   logic                       head_vld, skid_vld;
   logic [NUM_IDFR-1:0]        dec_ce;
   logic [INST_ID_LEN-1:0]     dec_id;
   logic                       dec_illegal, accept, xfer;

   inst_idfr_dispatch u_dispatch (
      .opcode   (in_inst[6:0]),
      .funct3   (in_inst[14:12]),
      .funct7   (in_inst[31:25]),
      .ce       (dec_ce),
      .instr_id (dec_id)
   );

   assign dec_illegal = ~|dec_ce || (dec_id == NONE_ID);
   assign new_e       = '{id: dec_id, inst: in_inst, pc: in_pc};
   assign in_ready    = (state == RUN) && !skid_vld && !flush;
   assign accept      = in_valid && in_ready;
   assign xfer        = head_vld && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         head_vld <= 1'b0;
         skid_vld <= 1'b0;
         head     <= '{id: NONE_ID, inst: '0, pc: '0};
         skid     <= '{id: NONE_ID, inst: '0, pc: '0};
         dec_cnt  <= '0;
      end else begin
         // A transfer completing in the flush cycle is still counted.
         if (xfer) dec_cnt <= dec_cnt + CNT_W'(1);
         if (flush) begin
            head_vld <= 1'b0;
            skid_vld <= 1'b0;
            state    <= RUN;
         end else begin
            if (xfer || !head_vld) begin
               if (skid_vld) begin
                  head     <= skid;
                  head_vld <= 1'b1;
                  skid_vld <= 1'b0;
               end else if (accept) begin
                  head     <= new_e;
                  head_vld <= 1'b1;
               end else begin
                  head_vld <= 1'b0;
               end
            end else if (accept) begin
               skid     <= new_e;
               skid_vld <= 1'b1;
            end
            if (accept && dec_illegal) state <= HALT;
         end
      end
   end

   assign out_valid    = head_vld;
   assign out_instr_id = head.id;
   assign out_inst     = head.inst;
   assign out_pc       = head.pc;
   assign out_illegal  = head_vld && (head.id == NONE_ID);
   assign halted       = (state == HALT);
endmodule

// File: tb/tb_inst_id_ctrl.sv
// Directed-vector bench for inst_id_ctrl: decode, backpressure, halt/flush,
// flush collision, throughput and asynchronous reset mid-stream.
module tb_inst_id_ctrl;
   logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_inst, in_pc, out_inst, out_pc, dec_cnt;
   logic [5:0]  out_instr_id;
   logic        out_illegal, halted;
   int          n_vec = 0, n_bad = 0;
   logic [31:0] exp_cnt;

   localparam logic [31:0] I_ORI  = 32'h00516093;
   localparam logic [31:0] I_ADDI = 32'h00500093;
   localparam logic [31:0] I_SUB  = 32'h40208033;
   localparam logic [31:0] I_LW   = 32'h0000a083;
   localparam logic [31:0] I_BEQ  = 32'h00000063;

   inst_id_ctrl dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr_id(out_instr_id),
      .out_inst(out_inst), .out_pc(out_pc), .out_illegal(out_illegal),
      .halted(halted), .dec_cnt(dec_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
      in_valid = v;
      in_inst  = inst;
      in_pc    = pc;
   endtask

   logic [31:0] dvec_inst [4];
   logic [5:0]  dvec_id   [4];

   initial begin
      dvec_inst = '{I_ADDI, I_SUB, I_LW, I_BEQ};
      dvec_id   = '{6'd19, 6'd29, 6'd13, 6'd5};
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, '0, '0);
      #3;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_instr_id", out_instr_id, 0);
      chk("rst_halted", halted, 0);
      chk("rst_dec_cnt", dec_cnt, 0);
      chk("rst_illegal", out_illegal, 0);
      rst_n = 1'b1;
      tick();

      // basic decode
      out_ready = 1'b1;
      drive(1'b1, I_ORI, 32'h100);
      #1 chk("basic_in_ready", in_ready, 1);
      tick();
      drive(1'b0, '0, '0);
      chk("basic_valid", out_valid, 1);
      chk("basic_id", out_instr_id, 23);
      chk("basic_pc", out_pc, 32'h100);
      chk("basic_illegal", out_illegal, 0);
      tick();
      chk("basic_cnt", dec_cnt, 1);
      chk("basic_drained", out_valid, 0);
      exp_cnt = 1;

      // decode table, back to back
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, dvec_inst[i], 32'h180 + 32'(i * 4));
         tick();
         chk("dec_id", out_instr_id, dvec_id[i]);
         chk("dec_inst", out_inst, dvec_inst[i]);
      end
      drive(1'b0, '0, '0);
      tick();
      exp_cnt += 4;
      chk("dec_cnt", dec_cnt, exp_cnt);

      // backpressure: two accepted, third held off until skid drains
      out_ready = 1'b0;
      drive(1'b1, I_ADDI, 32'h200); tick();
      drive(1'b1, I_ORI,  32'h204); tick();
      drive(1'b1, I_LW,   32'h208);
      #1 chk("bp_in_ready_full", in_ready, 0);
      tick();
      chk("bp_stable_pc", out_pc, 32'h200);
      tick();
      chk("bp_stable_pc2", out_pc, 32'h200);
      chk("bp_stable_id", out_instr_id, 19);
      out_ready = 1'b1;
      tick();
      chk("bp_second_pc", out_pc, 32'h204);
      chk("bp_in_ready_free", in_ready, 1);
      tick();
      drive(1'b0, '0, '0);
      chk("bp_third_pc", out_pc, 32'h208);
      chk("bp_third_id", out_instr_id, 13);
      tick();
      exp_cnt += 3;
      chk("bp_drained", out_valid, 0);
      chk("bp_cnt", dec_cnt, exp_cnt);

      // illegal instruction halts until flush
      out_ready = 1'b0;
      drive(1'b1, 32'h0, 32'h300); tick();
      chk("ill_halted", halted, 1);
      chk("ill_flag", out_illegal, 1);
      chk("ill_id", out_instr_id, 0);
      drive(1'b1, I_ORI, 32'h304);
      #1 chk("ill_in_ready", in_ready, 0);
      tick(); tick();
      chk("ill_head_pc", out_pc, 32'h300);
      out_ready = 1'b1;
      tick();
      exp_cnt += 1;
      chk("ill_not_accepted", out_valid, 0);
      chk("ill_still_halted", halted, 1);
      chk("ill_cnt", dec_cnt, exp_cnt);
      drive(1'b0, '0, '0);
      flush = 1'b1;
      #1 chk("flush_in_ready_low", in_ready, 0);
      tick();
      flush = 1'b0;
      #1;
      chk("flush_unhalt", halted, 0);
      chk("flush_in_ready", in_ready, 1);

      // flush collides with accept while both entries are full
      out_ready = 1'b0;
      drive(1'b1, I_ADDI, 32'h400); tick();
      drive(1'b1, I_SUB,  32'h404); tick();
      drive(1'b1, I_LW,   32'h408);
      flush = 1'b1; out_ready = 1'b1;
      tick();
      exp_cnt += 1;
      flush = 1'b0;
      drive(1'b0, '0, '0);
      chk("coll_valid", out_valid, 0);
      chk("coll_illegal", out_illegal, 0);
      chk("coll_cnt", dec_cnt, exp_cnt);
      tick();
      chk("coll_no_output", out_valid, 0);

      // throughput: 16 ORIs in 17 cycles
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, I_ORI, 32'h500 + 32'(i * 4));
         tick();
         chk("tp_pc", out_pc, 32'h500 + 32'(i * 4));
      end
      drive(1'b0, '0, '0);
      tick();
      exp_cnt += 16;
      chk("tp_cnt", dec_cnt, exp_cnt);
      chk("tp_drained", out_valid, 0);

      // reset mid-stream with two entries buffered and the block halted
      out_ready = 1'b0;
      drive(1'b1, I_ADDI, 32'h600); tick();
      drive(1'b1, 32'h0,  32'h604); tick();
      drive(1'b0, '0, '0);
      chk("pre_rst_halted", halted, 1);
      chk("pre_rst_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_cnt", dec_cnt, 0);
      chk("mid_rst_halted", halted, 0);
      chk("mid_rst_id", out_instr_id, 0);
      #3 rst_n = 1'b1;
      tick();
      chk("post_rst_valid", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
